cordic_arg_prep: RTL and testbench

Upstream input stage for the CORDIC function-evaluation custom instruction. Accepts an IEEE-754 single-precision angle in radians on the same `start`/`clk_en` handshake as the core. Converts it to signed fixed point with saturation and folds it into the CORDIC convergence range [-π/2, π/2]. Emits a cosine-negate flag that the core applies to its cosine result. Fully pipelined: one operand per enabled cycle, fixed 3-cycle latency.

---
 rtl/cordic_pkg.sv | 45 ++++
 rtl/fx_quadrant_fold.sv | 50 +++++
 rtl/cordic_arg_prep.sv | 146 ++++++++++++++
 tb/tb_cordic_arg_prep.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC argument path: float field layout, bias,
// fixed-point pi constants per FRAC_BITS and the float class enumeration.
package cordic_pkg;

  localparam int FLT_WIDTH = 32;
  localparam int SIGN_POS  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int EXP_BITS  = 8;
  localparam int MANT_BITS = 23;
  localparam int BIAS      = 127;

  localparam logic [EXP_BITS-1:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0]         FX_MAX       = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    FC_ZERO,
    FC_NORMAL,
    FC_INF,
    FC_NAN
  } float_class_e;

  // round(pi * 2^frac_bits); half pi is the same table one row down.
  function automatic logic [31:0] pi_q(input int frac_bits);
    case (frac_bits)
      19:      return 32'd1647099;
      20:      return 32'd3294199;
      21:      return 32'd6588397;
      22:      return 32'd13176795;
      23:      return 32'd26353589;
      24:      return 32'd52707179;
      25:      return 32'd105414357;
      26:      return 32'd210828714;
      27:      return 32'd421657428;
      28:      return 32'd843314857;
      29:      return 32'd1686629713;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] half_pi_q(input int frac_bits);
    return pi_q(frac_bits - 1);
  endfunction

endpackage

// File: rtl/fx_quadrant_fold.sv
// Final pipeline stage: folds a fixed-point angle into [-pi/2, pi/2] and
// registers the cosine-negate flag alongside it.
module fx_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        load,
  input  logic        no_fold,
  input  logic [31:0] angle_in,
  output logic [31:0] angle_out,
  output logic        negate
);

  localparam logic signed [31:0] PI_S      = signed'(pi_q(FRAC_BITS));
  localparam logic signed [31:0] HALF_PI_S = signed'(half_pi_q(FRAC_BITS));

  logic signed [31:0] a_in;
  logic signed [31:0] fold_angle;
  logic               fold_neg;

  assign a_in = signed'(angle_in);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fold_angle = a_in;
    fold_neg   = 1'b0;
    if (!no_fold && a_in > HALF_PI_S) begin
      fold_angle = a_in - PI_S;
      fold_neg   = 1'b1;
    end else if (!no_fold && a_in < -HALF_PI_S) begin
      fold_angle = a_in + PI_S;
      fold_neg   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_out <= '0;
      negate    <= 1'b0;
    end else if (clk_en && load) begin
      angle_out <= fold_angle;
      negate    <= fold_neg;
    end
  end

endmodule

// File: rtl/cordic_arg_prep.sv
// Float-to-fixed angle input stage for the CORDIC core, 3-stage pipeline.
// Define CORDIC_ARG_FOLD_EN to fold the result into [-pi/2, pi/2].
module cordic_arg_prep
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] angle,
  output logic        negate,
  output logic        sat,
  output logic        inv
);

  if (FRAC_BITS < 20 || FRAC_BITS > 29) begin : g_bad_frac_bits
    $error("cordic_arg_prep: FRAC_BITS must be within 20..29");
  end

  // S1 unpack
  logic               v1;
  logic               s1_sign;
  logic [EXP_BITS-1:0] s1_exp;
  logic [23:0]        s1_mant;
  float_class_e       s1_cls;

  logic [EXP_BITS-1:0] in_exp;
  logic [MANT_BITS-1:0] in_frac;
  float_class_e       in_cls;

  assign in_exp  = dataa[EXP_MSB:EXP_LSB];
  assign in_frac = dataa[MANT_BITS-1:0];

  always_comb begin
    in_cls = FC_NORMAL;
    if (in_exp == '0)                 in_cls = FC_ZERO;
    else if (in_exp == EXP_ALL_ONES)  in_cls = (in_frac == '0) ? FC_INF : FC_NAN;
  end

  // NOTE: the reset is asynchronous, so it belongs in the sensitivity list;
  // every register here is a plain flop and gets an explicit reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_mant <= '0;
      s1_cls  <= FC_ZERO;
    end else if (clk_en) begin
      // NOTE: sequential state uses non-blocking assignment only.
      v1 <= start;
      if (start) begin
        s1_sign <= dataa[SIGN_POS];
        s1_exp  <= in_exp;
        s1_mant <= {1'b1, in_frac};
        s1_cls  <= in_cls;
      end
    end
  end

  // S2 convert
  logic        v2;
  logic [31:0] s2_angle;
  logic        s2_sat;
  logic        s2_inv;

  int          exp_unb;
  int          shift;
  logic [31:0] mag;
  logic [31:0] conv_angle;
  logic        conv_sat;
  logic        conv_inv;

  always_comb begin
    exp_unb = int'({1'b0, s1_exp}) - BIAS;
    shift   = exp_unb + FRAC_BITS - MANT_BITS;
    mag     = '0;
    // Non-saturating normals have shift <= 7, so a 24-bit mantissa fits.
    if (shift >= 0)        mag = {8'd0, s1_mant} << 3'(shift);
    else if (shift > -24)  mag = {8'd0, s1_mant} >> 5'(-shift);
    conv_sat = (s1_cls == FC_INF) ||
               (s1_cls == FC_NORMAL && exp_unb >= 31 - FRAC_BITS);
    if (conv_sat) mag = FX_MAX;
    conv_angle = s1_sign ? -mag : mag;
    if (s1_cls == FC_ZERO || s1_cls == FC_NAN) conv_angle = '0;
    conv_inv = (s1_cls == FC_NAN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2       <= 1'b0;
      s2_angle <= '0;
      s2_sat   <= 1'b0;
      s2_inv   <= 1'b0;
    end else if (clk_en) begin
      v2 <= v1;
      if (v1) begin
        s2_angle <= conv_angle;
        s2_sat   <= conv_sat;
        s2_inv   <= conv_inv;
      end
    end
  end

  // S3 fold / output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      sat  <= 1'b0;
      inv  <= 1'b0;
    end else if (clk_en) begin
      done <= v2;
      if (v2) begin
        sat <= s2_sat;
        inv <= s2_inv;
      end
    end
  end

`ifdef CORDIC_ARG_FOLD_EN
  fx_quadrant_fold #(
    .FRAC_BITS(FRAC_BITS)
  ) u_fold (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     (v2),
    .no_fold  (s2_inv),
    .angle_in (s2_angle),
    .angle_out(angle),
    .negate   (negate)
  );
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             angle <= '0;
    else if (clk_en && v2) angle <= s2_angle;
  end

  assign negate = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arg_prep.sv
// Scoreboard bench for cordic_arg_prep (FRAC_BITS=29); expectations follow
// whether CORDIC_ARG_FOLD_EN is defined for the build.
module tb_cordic_arg_prep;

`ifdef CORDIC_ARG_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] angle;
    logic        negate;
    logic        sat;
    logic        inv;
    int          done_cyc;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        clk_en = 1'b0;
  logic        start  = 1'b0;
  logic [31:0] dataa  = '0;
  logic        done;
  logic [31:0] angle;
  logic        negate;
  logic        sat;
  logic        inv;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  cordic_arg_prep #(.FRAC_BITS(29)) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .done  (done),
    .angle (angle),
    .negate(negate),
    .sat   (sat),
    .inv   (inv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string ctx);
    check_bit({ctx, "_done"},   done,   1'b0);
    check    ({ctx, "_angle"},  angle,  32'sd0);
    check_bit({ctx, "_negate"}, negate, 1'b0);
    check_bit({ctx, "_sat"},    sat,    1'b0);
    check_bit({ctx, "_inv"},    inv,    1'b0);
  endtask

  // Called at posedge+1; the operand is sampled on the next edge and is
  // expected on done three edges after the current one.
  task automatic issue(input string tag, input logic [31:0] a, input int fold_ang,
                       input int plain_ang, input logic fneg, input logic fsat,
                       input logic finv);
    exp_t e;
    start      = 1'b1;
    dataa      = a;
    e.tag      = tag;
    e.angle    = FOLD ? fold_ang : plain_ang;
    e.negate   = FOLD & fneg;
    e.sat      = fsat;
    e.inv      = finv;
    e.done_cyc = cyc + 3;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Freeze the pipe for two edges while offering a junk operand that must be ignored.
  task automatic stall2();
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].done_cyc > cyc) sb[i].done_cyc += 2;
    clk_en = 1'b0;
    start  = 1'b1;
    dataa  = 32'h3F80_0000;
    repeat (2) @(posedge clk);
    #1;
    clk_en = 1'b1;
    start  = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: one pop per enabled cycle with done high.
  always @(negedge clk) begin
    if (rst && clk_en && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no output", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check    ({e.tag, "_angle"},   angle,  e.angle);
        check_bit({e.tag, "_negate"},  negate, e.negate);
        check_bit({e.tag, "_sat"},     sat,    e.sat);
        check_bit({e.tag, "_inv"},     inv,    e.inv);
        check    ({e.tag, "_latency"}, cyc,    e.done_cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b1;

    // Single operand, then idle so a stretched done pulse would be caught.
    issue("one", 32'h3F80_0000, 536870912, 536870912, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Back-to-back directed vectors: folding, saturation, specials, truncation.
    issue("three",      32'h4040_0000, -76016977,  1610612736,  1'b1, 1'b0, 1'b0);
    issue("neg_two",    32'hC000_0000, 612887889,  -1073741824, 1'b1, 1'b0, 1'b0);
    issue("five",       32'h40A0_0000, 460853934,  2147483647,  1'b1, 1'b1, 1'b0);
    issue("neg_inf",    32'hFF80_0000, -460853934, -2147483647, 1'b1, 1'b1, 1'b0);
    issue("nan",        32'h7FC0_0000, 0,          0,           1'b0, 1'b0, 1'b1);
    issue("denorm",     32'h0000_0001, 0,          0,           1'b0, 1'b0, 1'b0);
    issue("above_half", 32'h3FC9_0FDB, -843314833, 843314880,   1'b1, 1'b0, 1'b0);
    issue("below_half", 32'h3FC9_0FDA, 843314816,  843314816,   1'b0, 1'b0, 1'b0);
    issue("neg_above",  32'hBFC9_0FDB, 843314833,  -843314880,  1'b1, 1'b0, 1'b0);
    issue("near_four",  32'h407F_FFFF, 460853807,  2147483520,  1'b1, 1'b0, 1'b0);
    issue("four",       32'h4080_0000, 460853934,  2147483647,  1'b1, 1'b1, 1'b0);
    issue("trunc_pos",  32'h3380_0001, 32,         32,          1'b0, 1'b0, 1'b0);
    issue("trunc_neg",  32'hB380_0001, -32,        -32,         1'b0, 1'b0, 1'b0);
    issue("tiny",       32'h30FF_FFFF, 0,          0,           1'b0, 1'b0, 1'b0);
    issue("neg_zero",   32'h8000_0000, 0,          0,           1'b0, 1'b0, 1'b0);
    idle(1);
    drain();

    // Four back-to-back operands with a 2-cycle clock-enable drop mid-stream.
    issue("s_three",   32'h4040_0000, -76016977,  1610612736,  1'b1, 1'b0, 1'b0);
    issue("s_neg_two", 32'hC000_0000, 612887889,  -1073741824, 1'b1, 1'b0, 1'b0);
    stall2();
    issue("s_five",    32'h40A0_0000, 460853934,  2147483647,  1'b1, 1'b1, 1'b0);
    issue("s_neg_inf", 32'hFF80_0000, -460853934, -2147483647, 1'b1, 1'b1, 1'b0);
    idle(1);
    drain();

    // Reset with two operands in flight: outputs clear at once, nothing emerges.
    issue("lost_a", 32'h4040_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    issue("lost_b", 32'h40A0_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    #1 rst = 1'b0;
    sb.delete();
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    idle(8);
    check("post_reset_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
